// File: rtl/ams_crtc_pkg.sv
// Shared definitions for the simplified 6845-class CRTC: register map,
// vertical state encoding and the sync-width decode.
package ams_crtc_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned HCNT_W = 8;
   localparam int unsigned VCNT_W = 7;
   localparam int unsigned SW_W   = 4;

   // Register indices as seen through the address register
   localparam logic [ADDR_W-1:0] R_HTOT  = 5'd0;
   localparam logic [ADDR_W-1:0] R_HDISP = 5'd1;
   localparam logic [ADDR_W-1:0] R_HSPOS = 5'd2;
   localparam logic [ADDR_W-1:0] R_SYNCW = 5'd3;
   localparam logic [ADDR_W-1:0] R_VTOT  = 5'd4;
   localparam logic [ADDR_W-1:0] R_VADJ  = 5'd5;
   localparam logic [ADDR_W-1:0] R_VDISP = 5'd6;
   localparam logic [ADDR_W-1:0] R_VSPOS = 5'd7;
   localparam logic [ADDR_W-1:0] R_ILACE = 5'd8;
   localparam logic [ADDR_W-1:0] R_MAXRA = 5'd9;
   localparam logic [ADDR_W-1:0] R_SAHI  = 5'd12;
   localparam logic [ADDR_W-1:0] R_SALO  = 5'd13;

   typedef enum logic {
      V_ACTIVE = 1'b0,
      V_ADJUST = 1'b1
   } vstate_t;

   // A programmed width of 0 stands for the maximum of 16
   function automatic logic [SW_W:0] sync_width(input logic [SW_W-1:0] w);
      return (w == '0) ? 5'd16 : {1'b0, w};
   endfunction

endpackage

// File: rtl/sync_width_counter.sv
// Sync pulse stretcher: counts a programmed number of ticks after a start.
module sync_width_counter
   import ams_crtc_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_tick,
   input  logic            i_start,
   input  logic [SW_W-1:0] i_width,
   output logic            o_active
);

   logic [SW_W-1:0] r_cnt;
   logic            r_active;

   // Start only when idle so a repeated start cannot stretch a running pulse
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (i_tick) begin
         if (i_start && !r_active) begin
            r_active <= 1'b1;
            r_cnt    <= SW_W'(sync_width(i_width) - 5'd1);
         end else if (r_active) begin
            if (r_cnt == '0) r_active <= 1'b0;
            else             r_cnt    <= r_cnt - SW_W'(1);
         end
      end
   end

   assign o_active = r_active;

endmodule

// File: rtl/crtc_6845_lite.sv
// Simplified 6845-class CRTC: H/V timing, sync, display enable and MA/RA.
module crtc_6845_lite
   import ams_crtc_pkg::*;
#(
   parameter int unsigned MA_W = 14,
   parameter int unsigned RA_W = 5
)(
   input  logic            i_clk_n,
   input  logic            i_reset,
   input  logic            i_cclk,
   input  logic            i_cs_n,
   input  logic            i_rs,
   input  logic            i_wr_n,
   input  logic [7:0]      i_d,
   output logic            o_hsync,
   output logic            o_vsync,
   output logic            o_dispen,
   output logic [MA_W-1:0] o_ma,
   output logic [RA_W-1:0] o_ra
);

   logic              r_wr_n_d, r_wr_pend, r_wr_rs;
   logic [7:0]        r_wr_d;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_r0, r_r1, r_r2, r_r3, r_r13;
   logic [6:0]        r_r4, r_r6, r_r7;
   logic [4:0]        r_r5, r_r9;
   logic [5:0]        r_r12;

   logic [HCNT_W-1:0] r_hcnt, w_hcnt_nx;
   logic [VCNT_W-1:0] r_vcnt, w_vcnt_nx;
   logic [RA_W-1:0]   r_ra, w_ra_nx;
   logic [MA_W-1:0]   r_lstart, w_lstart_nx;
   vstate_t           r_vstate, w_vstate_nx;
   logic              w_eol, w_frame_end, w_row_end, w_wr_fall;
   logic              w_h_active, w_v_active, w_hs_start, w_vs_start;
   logic              r_hsync, r_vsync, r_dispen;
   logic [MA_W-1:0]   r_ma;
   logic [RA_W-1:0]   r_ra_out;

   assign w_wr_fall = r_wr_n_d & ~i_wr_n & ~i_cs_n;

   // Capture a CPU write on the WR_n falling edge; it commits one cycle later
   always_ff @(posedge i_clk_n or posedge i_reset) begin
      if (i_reset) begin
         r_wr_n_d  <= 1'b0;
         r_wr_pend <= 1'b0;
         r_wr_rs   <= 1'b0;
         r_wr_d    <= '0;
      end else begin
         r_wr_n_d  <= i_wr_n;
         r_wr_pend <= w_wr_fall;
         if (w_wr_fall) begin
            r_wr_rs <= i_rs;
            r_wr_d  <= i_d;
         end
      end
   end

   // Address register and timing register file
   always_ff @(posedge i_clk_n or posedge i_reset) begin
      if (i_reset) begin
         r_addr <= '0;
         r_r0 <= '0; r_r1 <= '0; r_r2 <= '0; r_r3 <= '0; r_r4 <= '0;
         r_r5 <= '0; r_r6 <= '0; r_r7 <= '0; r_r9 <= '0; r_r12 <= '0;
         r_r13 <= '0;
      end else if (r_wr_pend) begin
         if (!r_wr_rs) begin
            r_addr <= r_wr_d[4:0];
         end else begin
            case (r_addr)
               R_HTOT:  r_r0  <= r_wr_d;
               R_HDISP: r_r1  <= r_wr_d;
               R_HSPOS: r_r2  <= r_wr_d;
               R_SYNCW: r_r3  <= r_wr_d;
               R_VTOT:  r_r4  <= r_wr_d[6:0];
               R_VADJ:  r_r5  <= r_wr_d[4:0];
               R_VDISP: r_r6  <= r_wr_d[6:0];
               R_VSPOS: r_r7  <= r_wr_d[6:0];
               R_ILACE: ;
               R_MAXRA: r_r9  <= r_wr_d[4:0];
               R_SAHI:  r_r12 <= r_wr_d[5:0];
               R_SALO:  r_r13 <= r_wr_d;
               default: ;
            endcase
         end
      end
   end

   // Horizontal character counter; a total below HCNT lets it free-run to the wrap
   assign w_eol     = i_cclk && (r_hcnt == r_r0);
   assign w_hcnt_nx = w_eol ? '0 : r_hcnt + HCNT_W'(1);

   always_ff @(posedge i_clk_n or posedge i_reset) begin
      if (i_reset)     r_hcnt <= '0;
      else if (i_cclk) r_hcnt <= w_hcnt_nx;
   end

   // Vertical FSM state register and line/row counters
   always_ff @(posedge i_clk_n or posedge i_reset) begin
      if (i_reset) begin
         r_vstate <= V_ACTIVE;
         r_vcnt   <= '0;
         r_ra     <= '0;
         r_lstart <= '0;
      end else begin
         r_vstate <= w_vstate_nx;
         r_vcnt   <= w_vcnt_nx;
         r_ra     <= w_ra_nx;
         r_lstart <= w_lstart_nx;
      end
   end

   // Vertical next-state: raster/row stepping, adjust lines and line start address
   always_comb begin
      w_vstate_nx = r_vstate;
      w_vcnt_nx   = r_vcnt;
      w_ra_nx     = r_ra;
      w_lstart_nx = r_lstart;
      w_frame_end = 1'b0;
      w_row_end   = 1'b0;
      if (w_eol) begin
         case (r_vstate)
            V_ACTIVE: begin
               if (r_ra == RA_W'(r_r9)) begin
                  w_row_end = 1'b1;
                  w_ra_nx   = '0;
                  if (r_vcnt == r_r4) begin
                     if (r_r5 == '0) w_frame_end = 1'b1;
                     else            w_vstate_nx = V_ADJUST;
                  end else begin
                     w_vcnt_nx = r_vcnt + VCNT_W'(1);
                  end
               end else begin
                  w_ra_nx = r_ra + RA_W'(1);
               end
            end
            V_ADJUST: begin
               if (r_ra == RA_W'(r_r5 - 5'd1)) begin
                  w_frame_end = 1'b1;
                  w_vstate_nx = V_ACTIVE;
               end else begin
                  w_ra_nx = r_ra + RA_W'(1);
               end
            end
            default: w_vstate_nx = V_ACTIVE;
         endcase
         if (w_frame_end) begin
            w_vcnt_nx   = '0;
            w_ra_nx     = '0;
            w_lstart_nx = MA_W'({r_r12, r_r13});
         end else if (w_row_end) begin
            w_lstart_nx = MA_W'(r_lstart + MA_W'(r_r1));
         end
      end
   end

   // Sync starts are keyed on the counter values being loaded so the pulses
   // line up with the display-enable derived from the same counters
   assign w_hs_start = (w_hcnt_nx == r_r2);
   assign w_vs_start = (w_vstate_nx == V_ACTIVE) && (w_ra_nx == '0) && (w_vcnt_nx == r_r7);

   sync_width_counter u_hsync_w (
      .i_clk    (i_clk_n),
      .i_rst    (i_reset),
      .i_tick   (i_cclk),
      .i_start  (w_hs_start),
      .i_width  (r_r3[3:0]),
      .o_active (w_h_active)
   );

   sync_width_counter u_vsync_w (
      .i_clk    (i_clk_n),
      .i_rst    (i_reset),
      .i_tick   (w_eol),
      .i_start  (w_vs_start),
      .i_width  (r_r3[7:4]),
      .o_active (w_v_active)
   );

   // Output register stage: every pin changes on the same edge
   always_ff @(posedge i_clk_n or posedge i_reset) begin
      if (i_reset) begin
         r_hsync  <= 1'b0;
         r_vsync  <= 1'b0;
         r_dispen <= 1'b0;
         r_ma     <= '0;
         r_ra_out <= '0;
      end else begin
         r_hsync  <= w_h_active;
         r_vsync  <= w_v_active;
         r_dispen <= (r_hcnt < r_r1) && (r_vcnt < r_r6) && (r_vstate == V_ACTIVE);
         r_ma     <= MA_W'(r_lstart + MA_W'(r_hcnt));
         r_ra_out <= r_ra;
      end
   end

   assign o_hsync  = r_hsync;
   assign o_vsync  = r_vsync;
   assign o_dispen = r_dispen;
   assign o_ma     = r_ma;
   assign o_ra     = r_ra_out;

endmodule

// File: tb/tb_crtc_6845_lite.sv
// Directed bench for crtc_6845_lite with hand-computed expectations.
module tb_crtc_6845_lite;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cclk = 1'b0;
   logic        cs_n = 1'b1;
   logic        rs = 1'b0;
   logic        wr_n = 1'b1;
   logic [7:0]  d = 8'h00;
   logic        hsync, vsync, dispen;
   logic [13:0] ma;
   logic [4:0]  ra;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   crtc_6845_lite #(.MA_W(14), .RA_W(5)) dut (
      .i_clk_n  (clk),
      .i_reset  (rst),
      .i_cclk   (cclk),
      .i_cs_n   (cs_n),
      .i_rs     (rs),
      .i_wr_n   (wr_n),
      .i_d      (d),
      .o_hsync  (hsync),
      .o_vsync  (vsync),
      .o_dispen (dispen),
      .o_ma     (ma),
      .o_ra     (ra)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic sel, input logic [7:0] val);
      cs_n = 1'b0; rs = sel; d = val;
      tick(1);
      wr_n = 1'b0;
      tick(2);
      wr_n = 1'b1;
      tick(1);
      cs_n = 1'b1;
      tick(1);
   endtask

   task automatic wr_reg(input logic [4:0] a, input logic [7:0] v);
      bus_wr(1'b0, {3'b000, a});
      bus_wr(1'b1, v);
   endtask

   task automatic program_regs(input logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7, r9, r12, r13);
      wr_reg(5'd0, r0);  wr_reg(5'd1, r1);  wr_reg(5'd2, r2);  wr_reg(5'd3, r3);
      wr_reg(5'd4, r4);  wr_reg(5'd5, r5);  wr_reg(5'd6, r6);  wr_reg(5'd7, r7);
      wr_reg(5'd9, r9);  wr_reg(5'd12, r12); wr_reg(5'd13, r13);
   endtask

   task automatic do_reset();
      cclk = 1'b0;
      rst  = 1'b1;
      tick(2);
      rst  = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      n_checks += 5;
      if (hsync !== 1'b0)   begin n_fail++; $display("FAIL reset_hsync: got %b want 0", hsync); end
      if (vsync !== 1'b0)   begin n_fail++; $display("FAIL reset_vsync: got %b want 0", vsync); end
      if (dispen !== 1'b0)  begin n_fail++; $display("FAIL reset_dispen: got %b want 0", dispen); end
      if (ma !== 14'h0000)  begin n_fail++; $display("FAIL reset_ma: got %h want 0000", ma); end
      if (ra !== 5'd0)      begin n_fail++; $display("FAIL reset_ra: got %0d want 0", ra); end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_cpc_hsync();
      int r1 = -1, f1 = -1, r2 = -1;
      logic ph;
      logic [13:0] ma_r = '0;
      logic de_r = 1'b1;
      do_reset();
      program_regs(8'd63, 8'd40, 8'd46, 8'h8E, 8'd38, 8'd0, 8'd25, 8'd30, 8'd7, 8'h30, 8'h00);
      cclk = 1'b1;
      ph = hsync;
      for (int i = 0; i < 300 && r2 < 0; i++) begin
         tick(1);
         if (hsync && !ph) begin
            if (r1 < 0) begin r1 = i; ma_r = ma; de_r = dispen; end
            else r2 = i;
         end
         if (!hsync && ph && r1 >= 0 && f1 < 0) f1 = i;
         ph = hsync;
      end
      n_checks += 5;
      if (r2 < 0)         begin n_fail++; $display("FAIL hsync_found: second rise index %0d want >=0", r2); end
      if (r2 - r1 != 64)  begin n_fail++; $display("FAIL hsync_period: got %0d want 64", r2 - r1); end
      if (f1 - r1 != 14)  begin n_fail++; $display("FAIL hsync_width: got %0d want 14", f1 - r1); end
      if (ma_r !== 14'd46) begin n_fail++; $display("FAIL hsync_align_ma: got %0d want 46", ma_r); end
      if (de_r !== 1'b0)  begin n_fail++; $display("FAIL hsync_align_dispen: got %b want 0", de_r); end
   endtask

   // Continues the CPC run: waits for the first reloaded frame and checks it
   task automatic test_cpc_frame();
      int found = 0;
      int dcount = 0, vcount = 0, vrise = -1;
      logic pv;
      for (int i = 0; i < 21000 && found == 0; i++) begin
         tick(1);
         if (ma == 14'h3000) found = 1;
      end
      n_checks++;
      if (found == 0) begin n_fail++; $display("FAIL frame_sync: ma got %h want 3000", ma); end
      pv = vsync;
      for (int i = 0; i < 19968; i++) begin
         if (i == 512) begin
            n_checks += 3;
            if (ma !== 14'h3028) begin n_fail++; $display("FAIL line8_ma: got %h want 3028", ma); end
            if (ra !== 5'd0)     begin n_fail++; $display("FAIL line8_ra: got %0d want 0", ra); end
            if (dispen !== 1'b1) begin n_fail++; $display("FAIL line8_dispen: got %b want 1", dispen); end
         end
         if (i % 64 == 0 && i <= 576) begin
            n_checks++;
            if (ra !== 5'((i / 64) % 8)) begin
               n_fail++; $display("FAIL ra_cycle: line %0d got %0d want %0d", i / 64, ra, (i / 64) % 8);
            end
         end
         if (dispen) dcount++;
         if (vsync) begin
            vcount++;
            if (!pv && vrise < 0) vrise = i;
         end
         pv = vsync;
         tick(1);
      end
      n_checks += 5;
      if (ma !== 14'h3000)  begin n_fail++; $display("FAIL frame_len_ma: got %h want 3000", ma); end
      if (ra !== 5'd0)      begin n_fail++; $display("FAIL frame_len_ra: got %0d want 0", ra); end
      if (dcount != 8000)   begin n_fail++; $display("FAIL dispen_total: got %0d want 8000", dcount); end
      if (vcount != 512)    begin n_fail++; $display("FAIL vsync_width: got %0d want 512", vcount); end
      if (vrise != 15360)   begin n_fail++; $display("FAIL vsync_pos: got %0d want 15360", vrise); end
   endtask

   task automatic test_adjust();
      int exp_d[8]  = '{40, 0, 0, 0, 40, 0, 0, 0};
      int exp_ma[8] = '{0, 40, 40, 40, 0, 40, 40, 40};
      int exp_ra[8] = '{0, 0, 1, 2, 0, 0, 1, 2};
      int dc;
      logic [13:0] ma0;
      logic [4:0]  ra0;
      do_reset();
      program_regs(8'd63, 8'd40, 8'd46, 8'h8E, 8'd0, 8'd3, 8'd25, 8'd100, 8'd0, 8'h00, 8'h00);
      cclk = 1'b1;
      for (int l = 0; l < 8; l++) begin
         dc = 0; ma0 = '0; ra0 = '0;
         for (int i = 0; i < 64; i++) begin
            tick(1);
            if (i == 0) begin ma0 = ma; ra0 = ra; end
            if (dispen) dc++;
         end
         n_checks += 3;
         if (dc != exp_d[l])        begin n_fail++; $display("FAIL adj_dispen: line %0d got %0d want %0d", l, dc, exp_d[l]); end
         if (ma0 !== 14'(exp_ma[l])) begin n_fail++; $display("FAIL adj_ma: line %0d got %0d want %0d", l, ma0, exp_ma[l]); end
         if (ra0 !== 5'(exp_ra[l]))  begin n_fail++; $display("FAIL adj_ra: line %0d got %0d want %0d", l, ra0, exp_ra[l]); end
      end
   endtask

   task automatic test_sync_w16();
      int h_len = -1, h_cnt = 0, v_len = -1, v_cnt = 0;
      do_reset();
      program_regs(8'd63, 8'd40, 8'd46, 8'h00, 8'd38, 8'd0, 8'd25, 8'd2, 8'd7, 8'h00, 8'h00);
      cclk = 1'b1;
      for (int i = 0; i < 2500 && v_len < 0; i++) begin
         tick(1);
         if (hsync) h_cnt++;
         else begin
            if (h_cnt > 0 && h_len < 0) h_len = h_cnt;
            h_cnt = 0;
         end
         if (vsync) v_cnt++;
         else begin
            if (v_cnt > 0 && v_len < 0) v_len = v_cnt;
            v_cnt = 0;
         end
      end
      n_checks += 2;
      if (h_len != 16)   begin n_fail++; $display("FAIL hsync_w16: got %0d want 16", h_len); end
      if (v_len != 1024) begin n_fail++; $display("FAIL vsync_w16: got %0d want 1024", v_len); end
   endtask

   task automatic test_r0_shrink();
      do_reset();
      program_regs(8'd63, 8'd40, 8'd46, 8'h8E, 8'd38, 8'd0, 8'd25, 8'd30, 8'd7, 8'h00, 8'h00);
      cclk = 1'b1;
      tick(50);
      cclk = 1'b0;
      tick(1);
      wr_reg(5'd0, 8'd20);
      n_checks += 2;
      if (ma !== 14'd50) begin n_fail++; $display("FAIL shrink_hold_ma: got %0d want 50", ma); end
      if (ra !== 5'd0)   begin n_fail++; $display("FAIL shrink_hold_ra: got %0d want 0", ra); end
      cclk = 1'b1;
      tick(207);
      n_checks += 2;
      if (ma !== 14'd0) begin n_fail++; $display("FAIL shrink_wrap_ma: got %0d want 0", ma); end
      if (ra !== 5'd0)  begin n_fail++; $display("FAIL shrink_wrap_noeol: ra got %0d want 0", ra); end
      tick(20);
      n_checks += 2;
      if (ma !== 14'd20) begin n_fail++; $display("FAIL shrink_end_ma: got %0d want 20", ma); end
      if (ra !== 5'd0)   begin n_fail++; $display("FAIL shrink_end_ra: got %0d want 0", ra); end
      tick(1);
      n_checks += 2;
      if (ma !== 14'd0) begin n_fail++; $display("FAIL shrink_eol_ma: got %0d want 0", ma); end
      if (ra !== 5'd1)  begin n_fail++; $display("FAIL shrink_eol_ra: got %0d want 1", ra); end
      tick(21);
      n_checks += 2;
      if (ma !== 14'd0) begin n_fail++; $display("FAIL shrink_period_ma: got %0d want 0", ma); end
      if (ra !== 5'd2)  begin n_fail++; $display("FAIL shrink_period_ra: got %0d want 2", ra); end
   endtask

   task automatic test_reset_mid();
      int found = 0;
      do_reset();
      program_regs(8'd63, 8'd40, 8'd46, 8'h8E, 8'd38, 8'd0, 8'd25, 8'd30, 8'd7, 8'h30, 8'h00);
      cclk = 1'b1;
      for (int i = 0; i < 200 && found == 0; i++) begin
         tick(1);
         if (hsync) found = 1;
      end
      n_checks++;
      if (found == 0) begin n_fail++; $display("FAIL mid_hsync_high: got %b want 1", hsync); end
      #2 rst = 1'b1;
      #1;
      n_checks += 5;
      if (hsync !== 1'b0)  begin n_fail++; $display("FAIL mid_reset_hsync: got %b want 0", hsync); end
      if (vsync !== 1'b0)  begin n_fail++; $display("FAIL mid_reset_vsync: got %b want 0", vsync); end
      if (dispen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_dispen: got %b want 0", dispen); end
      if (ma !== 14'd0)    begin n_fail++; $display("FAIL mid_reset_ma: got %h want 0000", ma); end
      if (ra !== 5'd0)     begin n_fail++; $display("FAIL mid_reset_ra: got %0d want 0", ra); end
      tick(2);
      rst = 1'b0;
      tick(5);
      n_checks += 3;
      if (ma !== 14'd0)    begin n_fail++; $display("FAIL release_ma: got %h want 0000", ma); end
      if (ra !== 5'd0)     begin n_fail++; $display("FAIL release_ra: got %0d want 0", ra); end
      if (dispen !== 1'b0) begin n_fail++; $display("FAIL release_dispen: got %b want 0", dispen); end
   endtask

   initial begin
      test_reset();
      test_cpc_hsync();
      test_cpc_frame();
      test_adjust();
      test_sync_w16();
      test_r0_shrink();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
